// File: rtl/cvae_check_pkg.sv
// Shared FSM encoding and default geometry for the CVAE run checker.
// IDLE is encoded as zero so the reset value of the debug state port is 0.
package cvae_check_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_ADDR_WIDTH  = 16;
   localparam int DEF_INIT_WORDS  = 23;
   localparam int DEF_STATE_WORDS = 13;
   localparam int DEF_GOLD_DEPTH  = 780;
   localparam int DEF_SEQ_WIDTH   = 6;
   localparam int DEF_CYC_WIDTH   = 24;
   localparam int DEF_ERR_WIDTH   = 16;
   localparam int DEF_MAX_CYCLES  = 220000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } cvae_state_e;

endpackage

// File: rtl/cvae_write_cmp.sv
// Snoops state-SRAM writes, compares each against the golden ROM one cycle later,
// and keeps the saturating error count, first-error address and write count.
module cvae_write_cmp #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int ERR_WIDTH   = 16,
   parameter int STATE_WORDS = 13,
   parameter int GOLD_DEPTH  = 780
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  snoop_en_i,
   input  logic                  err_inc_i,
   input  logic                  mon_wea_i,
   input  logic [ADDR_WIDTH-1:0] mon_addr_i,
   input  logic [DATA_WIDTH-1:0] mon_wdata_i,
   output logic [ADDR_WIDTH-1:0] gold_addr_o,
   input  logic [DATA_WIDTH-1:0] gold_rdata_i,
   output logic [ERR_WIDTH-1:0]  err_cnt_o,
   output logic [ADDR_WIDTH-1:0] first_err_addr_o,
   output logic [ADDR_WIDTH:0]   wr_cnt_o
);

   logic                  wr_v_q, wr_v_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [ERR_WIDTH-1:0]  err_q, err_d;
   logic [ADDR_WIDTH-1:0] first_q, first_d;
   logic                  seen_q, seen_d;
   logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
   logic                  cap;
   logic                  bad;
   logic [ERR_WIDTH:0]    err_sum;

   assign cap = snoop_en_i & mon_wea_i;
   // Golden ROM is addressed with the live write address so its data lines up with the capture.
   assign gold_addr_o = cap ? mon_addr_i : '0;

   assign bad = wr_v_q & ((wr_addr_q < ADDR_WIDTH'(STATE_WORDS)) |
                          (wr_addr_q >= ADDR_WIDTH'(GOLD_DEPTH)) |
                          (wr_data_q != gold_rdata_i));

   always_comb begin
      wr_v_d    = cap;
      wr_addr_d = cap ? mon_addr_i : wr_addr_q;
      wr_data_d = cap ? mon_wdata_i : wr_data_q;
      err_sum   = {1'b0, err_q} + (ERR_WIDTH+1)'(bad) + (ERR_WIDTH+1)'(err_inc_i);
      err_d     = err_sum[ERR_WIDTH] ? '1 : err_sum[ERR_WIDTH-1:0];
      first_d   = first_q;
      seen_d    = seen_q;
      wr_cnt_d  = wr_cnt_q;
      if (bad && !seen_q) begin
         first_d = wr_addr_q;
         seen_d  = 1'b1;
      end
      if (cap && (wr_cnt_q != '1)) begin
         wr_cnt_d = wr_cnt_q + (ADDR_WIDTH+1)'(1);
      end
      if (clear_i) begin
         wr_v_d   = 1'b0;
         err_d    = '0;
         first_d  = '0;
         seen_d   = 1'b0;
         wr_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_v_q    <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= '0;
         first_q   <= '0;
         seen_q    <= 1'b0;
         wr_cnt_q  <= '0;
      end else begin
         wr_v_q    <= wr_v_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
         first_q   <= first_d;
         seen_q    <= seen_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   assign err_cnt_o        = err_q;
   assign first_err_addr_o = first_q;
   assign wr_cnt_o         = wr_cnt_q;

endmodule

// File: rtl/cvae_run_checker.sv
// Run harness for CVAE_top: start pulse, init burst, cycle counting with watchdog,
// and a pass/fail status block fed by the write comparator.
module cvae_run_checker
   import cvae_check_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int INIT_WORDS  = DEF_INIT_WORDS,
   parameter int STATE_WORDS = DEF_STATE_WORDS,
   parameter int GOLD_DEPTH  = DEF_GOLD_DEPTH,
   parameter int SEQ_WIDTH   = DEF_SEQ_WIDTH,
   parameter int CYC_WIDTH   = DEF_CYC_WIDTH,
   parameter int ERR_WIDTH   = DEF_ERR_WIDTH,
   parameter int MAX_CYCLES  = DEF_MAX_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go,
   output logic                  dut_start,
   output logic [DATA_WIDTH-1:0] init_data,
   output logic [ADDR_WIDTH-1:0] init_addr,
   input  logic [DATA_WIDTH-1:0] init_rdata,
   input  logic                  dut_finish,
   input  logic [SEQ_WIDTH-1:0]  dut_seq_lens,
   input  logic                  mon_wea,
   input  logic [ADDR_WIDTH-1:0] mon_addr,
   input  logic [DATA_WIDTH-1:0] mon_wdata,
   output logic [ADDR_WIDTH-1:0] gold_addr,
   input  logic [DATA_WIDTH-1:0] gold_rdata,
   input  logic [SEQ_WIDTH-1:0]  gold_seq_lens,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic                  len_ok,
   output logic                  cnt_ok,
   output logic [ERR_WIDTH-1:0]  err_cnt,
   output logic [CYC_WIDTH-1:0]  cyc_cnt,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output cvae_state_e           dbg_state_o
);

   cvae_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
   logic [CYC_WIDTH-1:0]  cyc_q, cyc_d;
   logic                  timeout_q, timeout_d;
   logic                  len_ok_q, len_ok_d;
   logic                  cnt_ok_q, cnt_ok_d;
   logic                  clr;
   logic                  fin_in_load;
   logic [CYC_WIDTH-1:0]  cyc_inc;
   logic                  wd_hit;
   logic [ADDR_WIDTH:0]   exp_wr;
   logic [ADDR_WIDTH:0]   wr_cnt;
   logic [ERR_WIDTH-1:0]  err_cnt_w;
   logic                  snoop_en;

   assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CYC_WIDTH'(1);
   // The watchdog fires on the edge where the count reaches the limit, so DONE
   // lands two cycles later just like a normal finish.
   assign wd_hit  = (cyc_inc >= CYC_WIDTH'(MAX_CYCLES));
   assign exp_wr  = (ADDR_WIDTH+1)'(dut_seq_lens) * (ADDR_WIDTH+1)'(STATE_WORDS);

   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      cyc_d       = cyc_q;
      timeout_d   = timeout_q;
      len_ok_d    = len_ok_q;
      cnt_ok_d    = cnt_ok_q;
      clr         = 1'b0;
      fin_in_load = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // Status is cleared on the go edge so it already reads zero during START.
            if (go) begin
               clr       = 1'b1;
               ld_cnt_d  = '0;
               cyc_d     = '0;
               timeout_d = 1'b0;
               len_ok_d  = 1'b0;
               cnt_ok_d  = 1'b0;
               state_d   = ST_START;
            end
         end
         ST_START: state_d = ST_LOAD;
         ST_LOAD: begin
            cyc_d    = cyc_inc;
            ld_cnt_d = ld_cnt_q + ADDR_WIDTH'(1);
            if (dut_finish) begin
               fin_in_load = 1'b1;
               state_d     = ST_DRAIN;
            end else if (wd_hit) begin
               timeout_d = 1'b1;
               state_d   = ST_DRAIN;
            end else if (ld_cnt_q == ADDR_WIDTH'(INIT_WORDS - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cyc_d = cyc_inc;
            if (dut_finish) begin
               state_d = ST_DRAIN;
            end else if (wd_hit) begin
               timeout_d = 1'b1;
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            len_ok_d = (dut_seq_lens == gold_seq_lens);
            cnt_ok_d = (wr_cnt == exp_wr);
            state_d  = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ld_cnt_q  <= '0;
         cyc_q     <= '0;
         timeout_q <= 1'b0;
         len_ok_q  <= 1'b0;
         cnt_ok_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         cyc_q     <= cyc_d;
         timeout_q <= timeout_d;
         len_ok_q  <= len_ok_d;
         cnt_ok_q  <= cnt_ok_d;
      end
   end

   assign snoop_en = (state_q == ST_LOAD) || (state_q == ST_RUN);

   cvae_write_cmp #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .ERR_WIDTH   (ERR_WIDTH),
      .STATE_WORDS (STATE_WORDS),
      .GOLD_DEPTH  (GOLD_DEPTH)
   ) u_cmp (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .clear_i          (clr),
      .snoop_en_i       (snoop_en),
      .err_inc_i        (fin_in_load),
      .mon_wea_i        (mon_wea),
      .mon_addr_i       (mon_addr),
      .mon_wdata_i      (mon_wdata),
      .gold_addr_o      (gold_addr),
      .gold_rdata_i     (gold_rdata),
      .err_cnt_o        (err_cnt_w),
      .first_err_addr_o (first_err_addr),
      .wr_cnt_o         (wr_cnt)
   );

   assign dut_start   = (state_q == ST_START);
   assign init_addr   = (state_q == ST_LOAD) ? ld_cnt_q + ADDR_WIDTH'(1) : '0;
   assign init_data   = (state_q == ST_LOAD) ? init_rdata : '0;
   assign done        = (state_q == ST_DONE);
   assign timeout     = timeout_q;
   assign len_ok      = len_ok_q;
   assign cnt_ok      = cnt_ok_q;
   assign err_cnt     = err_cnt_w;
   assign cyc_cnt     = cyc_q;
   assign pass        = done & len_ok_q & cnt_ok_q & (err_cnt_w == '0) & ~timeout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cvae_run_checker.sv
// Directed and randomized runs of cvae_run_checker against a write-list reference model.
module tb_cvae_run_checker;
   import cvae_check_pkg::*;

   localparam int DW = 32, AW = 16, SQW = 6, CW = 24, EW = 16;
   localparam int NINIT = 23, STW = 13, GDEP = 780, MAXC = 1000;

   logic          clk = 1'b0, rst_n = 1'b0, go = 1'b0;
   logic          dut_start, done, pass, timeout, len_ok, cnt_ok;
   logic [DW-1:0] init_data, init_rdata = '0, gold_rdata = '0, mon_wdata = '0;
   logic [AW-1:0] init_addr, gold_addr, first_err_addr, mon_addr = '0;
   logic          dut_finish = 1'b0, mon_wea = 1'b0;
   logic [SQW-1:0] dut_seq_lens = '0, gold_seq_lens = '0;
   logic [EW-1:0] err_cnt;
   logic [CW-1:0] cyc_cnt;
   cvae_state_e   dbg_state;

   logic [DW-1:0] init_rom [0:31];
   logic [DW-1:0] gold_rom [0:1023];

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t wq[$];

   int rel, checks, errors;

   cvae_run_checker #(.MAX_CYCLES(MAXC)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .dut_start(dut_start),
      .init_data(init_data), .init_addr(init_addr), .init_rdata(init_rdata),
      .dut_finish(dut_finish), .dut_seq_lens(dut_seq_lens),
      .mon_wea(mon_wea), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
      .gold_addr(gold_addr), .gold_rdata(gold_rdata), .gold_seq_lens(gold_seq_lens),
      .done(done), .pass(pass), .timeout(timeout), .len_ok(len_ok), .cnt_ok(cnt_ok),
      .err_cnt(err_cnt), .cyc_cnt(cyc_cnt), .first_err_addr(first_err_addr),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // 1-cycle latency ROM models
   always @(posedge clk) begin
      init_rdata <= init_rom[init_addr[4:0]];
      gold_rdata <= gold_rom[gold_addr[9:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rel++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ":dut_start"}, 64'(dut_start), 64'd0);
      check({tag, ":init_data"}, 64'(init_data), 64'd0);
      check({tag, ":init_addr"}, 64'(init_addr), 64'd0);
      check({tag, ":gold_addr"}, 64'(gold_addr), 64'd0);
      check({tag, ":done"}, 64'(done), 64'd0);
      check({tag, ":pass"}, 64'(pass), 64'd0);
      check({tag, ":timeout"}, 64'(timeout), 64'd0);
      check({tag, ":len_ok"}, 64'(len_ok), 64'd0);
      check({tag, ":cnt_ok"}, 64'(cnt_ok), 64'd0);
      check({tag, ":err_cnt"}, 64'(err_cnt), 64'd0);
      check({tag, ":cyc_cnt"}, 64'(cyc_cnt), 64'd0);
      check({tag, ":first_err"}, 64'(first_err_addr), 64'd0);
      check({tag, ":state"}, 64'(dbg_state), 64'(ST_IDLE));
   endtask

   // go pulse, START cycle, then the full init burst
   task automatic load_phase(input string tag);
      go = 1'b1;
      tick();
      go = 1'b0;
      rel = 0;
      check({tag, ":start"}, 64'(dut_start), 64'd1);
      check({tag, ":start_addr"}, 64'(init_addr), 64'd0);
      check({tag, ":start_done"}, 64'(done), 64'd0);
      check({tag, ":start_err"}, 64'(err_cnt), 64'd0);
      check({tag, ":start_cyc"}, 64'(cyc_cnt), 64'd0);
      check({tag, ":start_pass"}, 64'(pass), 64'd0);
      for (int i = 0; i < NINIT; i++) begin
         tick();
         check($sformatf("%s:init%0d", tag, i), 64'(init_data), 64'(init_rom[i]));
         if (i == 0) check({tag, ":start_low"}, 64'(dut_start), 64'd0);
      end
   endtask

   task automatic write_phase(input string tag, input int fin_min, input int go_at,
                              input logic [SQW-1:0] seq, input logic [SQW-1:0] gseq,
                              input bit rnd_gaps);
      int fin, e;
      logic [AW-1:0] fa;
      bit got, bad, exp_len, exp_cnt;
      gold_seq_lens = gseq;
      tick();
      foreach (wq[k]) begin
         mon_wea = 1'b1;
         mon_addr = wq[k].addr;
         mon_wdata = wq[k].data;
         tick();
         mon_wea = 1'b0;
         mon_addr = '0;
         mon_wdata = '0;
         if (rnd_gaps) repeat ($urandom_range(0, 2)) tick();
      end
      fin = (fin_min > rel) ? fin_min : rel;
      while (rel < fin) begin
         if (rel == go_at) go = 1'b1;
         tick();
         if (go) begin
            go = 1'b0;
            check({tag, ":go_ignored_start"}, 64'(dut_start), 64'd0);
            check({tag, ":go_ignored_state"}, 64'(dbg_state), 64'(ST_RUN));
         end
      end
      dut_finish = 1'b1;
      dut_seq_lens = seq;
      tick();
      dut_finish = 1'b0;
      check({tag, ":drain_done"}, 64'(done), 64'd0);
      tick();
      e = 0; fa = '0; got = 1'b0;
      foreach (wq[k]) begin
         bad = (wq[k].addr < AW'(STW)) || (wq[k].addr >= AW'(GDEP)) ||
               (wq[k].data != gold_rom[wq[k].addr[9:0]]);
         if (bad) begin
            e++;
            if (!got) begin
               fa = wq[k].addr;
               got = 1'b1;
            end
         end
      end
      exp_len = (seq == gseq);
      exp_cnt = (wq.size() == int'(seq) * STW);
      check({tag, ":done"}, 64'(done), 64'd1);
      check({tag, ":cyc_cnt"}, 64'(cyc_cnt), 64'(fin));
      check({tag, ":err_cnt"}, 64'(err_cnt), 64'(e));
      check({tag, ":first_err"}, 64'(first_err_addr), 64'(fa));
      check({tag, ":len_ok"}, 64'(len_ok), 64'(exp_len));
      check({tag, ":cnt_ok"}, 64'(cnt_ok), 64'(exp_cnt));
      check({tag, ":timeout"}, 64'(timeout), 64'd0);
      check({tag, ":pass"}, 64'(pass), 64'(exp_len && exp_cnt && e == 0));
   endtask

   task automatic push_good(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) wq.push_back('{addr: AW'(a), data: gold_rom[a]});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rel = 0;
      for (int i = 0; i < 1024; i++) gold_rom[i] = $urandom;
      for (int i = 0; i < 32; i++) init_rom[i] = 32'h100 + i;

      // reset
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // golden run, fixed 300-cycle finish
      load_phase("gold");
      wq.delete();
      push_good(13, 25);
      write_phase("gold", 300, -1, 6'd1, 6'd1, 1'b0);

      // single mismatch; also a go pulse mid-RUN that must be ignored
      tick();
      load_phase("mism");
      wq.delete();
      push_good(13, 25);
      wq[7].data = wq[7].data ^ 32'h1;
      write_phase("mism", 200, 100, 6'd1, 6'd1, 1'b1);

      // range violations
      load_phase("range");
      wq.delete();
      wq.push_back('{addr: AW'(5), data: gold_rom[5]});
      wq.push_back('{addr: AW'(780), data: gold_rom[780]});
      push_good(13, 23);
      write_phase("range", 0, -1, 6'd1, 6'd1, 1'b1);

      // length checks
      load_phase("len_cnt");
      wq.delete();
      push_good(13, 50);
      write_phase("len_cnt", 0, -1, 6'd3, 6'd3, 1'b1);
      load_phase("len_gold");
      wq.delete();
      push_good(13, 51);
      write_phase("len_gold", 0, -1, 6'd3, 6'd4, 1'b1);

      // randomized runs
      for (int r = 0; r < 6; r++) begin
         int n, a, sel;
         bit clean;
         logic [SQW-1:0] seq, gseq;
         logic [DW-1:0] d;
         for (int i = 0; i < NINIT; i++) init_rom[i] = $urandom;
         clean = (r % 2 == 0);
         seq = SQW'($urandom_range(1, 3));
         gseq = (clean || $urandom_range(0, 1) == 1) ? seq : seq + SQW'(1);
         n = int'(seq) * STW;
         if (!clean) n = n + $urandom_range(0, 2) - 1;
         wq.delete();
         for (int k = 0; k < n; k++) begin
            sel = clean ? 99 : $urandom_range(0, 39);
            if (sel == 0) a = $urandom_range(0, 12);
            else if (sel == 1) a = $urandom_range(780, 799);
            else a = $urandom_range(13, 779);
            d = gold_rom[a];
            if (sel == 2) d = d ^ (32'h1 << $urandom_range(0, 31));
            wq.push_back('{addr: AW'(a), data: d});
         end
         load_phase($sformatf("rnd%0d", r));
         write_phase($sformatf("rnd%0d", r), $urandom_range(0, 150), -1, seq, gseq, 1'b1);
      end

      // watchdog: no finish
      load_phase("wdog");
      while (rel < MAXC + 1) tick();
      check("wdog:timeout_drain", 64'(timeout), 64'd1);
      check("wdog:drain_done", 64'(done), 64'd0);
      tick();
      check("wdog:done", 64'(done), 64'd1);
      check("wdog:timeout", 64'(timeout), 64'd1);
      check("wdog:cyc_cnt", 64'(cyc_cnt), 64'(MAXC));
      check("wdog:pass", 64'(pass), 64'd0);

      // reset mid-RUN
      for (int i = 0; i < NINIT; i++) init_rom[i] = 32'h100 + i;
      load_phase("midrst");
      tick();
      mon_wea = 1'b1;
      mon_addr = AW'(3);
      mon_wdata = gold_rom[3];
      tick();
      mon_wea = 1'b0;
      mon_addr = '0;
      mon_wdata = '0;
      tick();
      check("midrst:err_before", 64'(err_cnt), 64'd1);
      check("midrst:first_before", 64'(first_err_addr), 64'd3);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // fresh run from IDLE after reset
      load_phase("rerun");
      wq.delete();
      push_good(13, 25);
      write_phase("rerun", 60, -1, 6'd1, 6'd1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cvae_run_checker.md
# cvae_run_checker

Synthesizable run harness and scoreboard for `CVAE_top`. On `go` it pulses the accelerator start, streams a configurable initial-data burst from an init ROM, and counts cycles until `finish`. It snoops every state-SRAM write and compares it against a golden ROM, then checks the total write count against the reported sequence length. It sits beside `CVAE_top` in FPGA/emulation builds and replaces bench-only checking with a pass/fail status block.

## Interface
- `DATA_WIDTH`, 32, word width of init, state and golden data
- `ADDR_WIDTH`, 16, state/golden/init address width
- `INIT_WORDS`, 23, words streamed after start (13 state + 6 goal + 4 Z)
- `STATE_WORDS`, 13, words per timestep; region `[0, STATE_WORDS)` is init-only
- `GOLD_DEPTH`, 780, valid golden/state depth
- `SEQ_WIDTH`, 6, width of `seq_lens`
- `CYC_WIDTH`, 24, cycle counter width (saturating)
- `ERR_WIDTH`, 16, error counter width (saturating)
- `MAX_CYCLES`, 220000, watchdog limit

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous active-low reset
- `go` in 1 — run request pulse
- `dut_start` out 1 — one-cycle start to `CVAE_top`
- `init_data` out DATA_WIDTH — burst word to `CVAE_top`
- `init_addr` out ADDR_WIDTH / `init_rdata` in DATA_WIDTH — init ROM, 1-cycle read latency
- `dut_finish` in 1, `dut_seq_lens` in SEQ_WIDTH — from `CVAE_top`
- `mon_wea` in 1, `mon_addr` in ADDR_WIDTH, `mon_wdata` in DATA_WIDTH — snooped state-SRAM write port
- `gold_addr` out ADDR_WIDTH / `gold_rdata` in DATA_WIDTH — golden ROM, 1-cycle latency
- `gold_seq_lens` in SEQ_WIDTH — expected sequence length
- `done`, `pass`, `timeout`, `len_ok`, `cnt_ok` out 1 — status
- `err_cnt` out ERR_WIDTH, `cyc_cnt` out CYC_WIDTH, `first_err_addr` out ADDR_WIDTH

## Operation
- FSM states: IDLE → START → LOAD → RUN → DRAIN → DONE. DONE → START on `go`. IDLE → START on `go`.
- **START** (1 cycle):
  - `dut_start`=1 and `init_addr`=0.
  - Clears all counters and status; `done`=0.
- **LOAD** (INIT_WORDS cycles):
  - `init_addr`=i+1 while `init_data`=`init_rdata` (word i).
  - `init_data`=0 outside LOAD.
- **RUN**:
  - Each `mon_wea` cycle is registered with its data.
  - `gold_addr`=`mon_addr` combinationally in that cycle; the compare happens the next cycle.
  - A mismatch, an address < STATE_WORDS, or an address ≥ GOLD_DEPTH increments `err_cnt` (saturating).
  - `first_err_addr` latches the address of the first such error.
  - `wr_cnt` increments on every write.
- Snooping is active in LOAD, RUN and the `dut_finish` cycle; `mon_wea` is ignored in IDLE, START, DRAIN and DONE.
- On `dut_finish`, or a `dut_finish` arriving in LOAD, → DRAIN.
  - A finish in LOAD also counts one error.
  - DRAIN is one cycle to retire the compare pipeline.
- **DONE**:
  - `len_ok` = (`dut_seq_lens` == `gold_seq_lens`).
  - `cnt_ok` = (`wr_cnt` == `dut_seq_lens`·STATE_WORDS); the product width is ADDR_WIDTH+1.
  - `pass` = `len_ok` & `cnt_ok` & (`err_cnt`==0) & !`timeout`.
- **Watchdog**: if `cyc_cnt` reaches MAX_CYCLES in LOAD or RUN, `timeout`=1 → DRAIN.
- `go` is ignored in START, LOAD, RUN and DRAIN.

## Timing
- Reset values: all outputs 0, FSM = IDLE.
- `dut_start` is high exactly the cycle after `go` is sampled.
- Init word 0 is on `init_data` at start+1; word INIT_WORDS−1 is at start+INIT_WORDS.
- `cyc_cnt`:
  - Increments each cycle from start+1 through the cycle `dut_finish` is first sampled high, inclusive.
  - Saturates at all-ones.
- Compare latency: 1 cycle. Back-to-back writes are compared at full rate.
- `done` and status are valid 2 cycles after `dut_finish` is sampled, and hold until the next START.
- Reset mid-run aborts immediately to IDLE with all outputs 0.

## Structure
- Package `cvae_check_pkg`: FSM state enum, default parameter constants.
- Sub-module `cvae_write_cmp`:
  - Contents: the registered write capture, compare, range check, saturating error counter and first-error latch.
  - Parametrised on DATA_WIDTH, ADDR_WIDTH, ERR_WIDTH, STATE_WORDS, GOLD_DEPTH.
- Top holds the FSM, burst addressing, cycle counter and watchdog.

## Test plan
- **Golden run.** Stimulus: `go`; init ROM words 0..22 = 0x100+i; model writes addrs 13..25 matching golden; finish at start+300 with `seq_lens`=`gold_seq_lens`=1. Required: `init_data` sequence 0x100..0x116 at start+1..start+23; `cyc_cnt`=300; `pass`=1; `err_cnt`=0.
- **Single mismatch.** Stimulus: addr 20 written with golden^1. Required: `err_cnt`=1, `first_err_addr`=20, `pass`=0, `cnt_ok`=1.
- **Range violations.** Stimulus: writes to addr 5 and addr 780. Required: `err_cnt`=2, `first_err_addr`=5.
- **Length checks.**
  - `seq_lens`=3 with 38 writes → `cnt_ok`=0, `len_ok`=1.
  - `gold_seq_lens`=4 → `len_ok`=0.
- **Watchdog.** Stimulus: MAX_CYCLES=1000, no finish. Required: `timeout`=1 and `done`=1 at start+1002.
- **Reset and re-run.**
  - `rst_n` low mid-RUN → all outputs 0 immediately.
  - `go` during RUN → ignored.
  - `go` in DONE → fresh run with counters cleared.
